// File: rtl/spiro_predict.sv
// Spirometry percent-of-predicted evaluator.
// Table lookup of predicted FVC, restoring divide, severity class.
module spiro_predict #(
    parameter int W_MEAS = 10,
    parameter int W_PRED = 10,
    parameter int W_PCT  = 8
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iCE,
    input  logic              iStart,
    input  logic [7:0]        ivEdad,
    input  logic              iSexo,
    input  logic [W_MEAS-1:0] ivMedida,
    output logic [W_PRED-1:0] ovPred,
    output logic [W_PCT-1:0]  ovPct,
    output logic [1:0]        ovClase,
    output logic              oBusy,
    output logic              oDone
);

    localparam int NW = W_MEAS + 7;
    localparam int CW = $clog2(NW + 1);
    localparam logic [CW-1:0] LAST = CW'(NW - 1);
    localparam logic [NW-1:0] PCT_MAX = NW'((1 << W_PCT) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [7:0]        age_q, age_d;
    logic              sexo_q, sexo_d;
    logic [NW-1:0]     num_q, num_d;
    logic [W_PRED-1:0] pred_q, pred_d;
    logic [W_PRED-1:0] rem_q, rem_d;
    logic [NW-1:0]     quo_q, quo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W_PRED-1:0] out_pred_q, out_pred_d;
    logic [W_PCT-1:0]  out_pct_q, out_pct_d;
    logic [1:0]        out_clase_q, out_clase_d;
    logic              done_q, done_d;

    logic [W_PRED-1:0] tbl;
    logic [W_PRED-1:0] pred_tbl;
    logic [W_PRED:0]   rem_sh;
    logic [W_PRED-1:0] rem_nx;
    logic              qbit;
    logic [NW-1:0]     quo_nx;
    logic [W_PCT-1:0]  pct_nx;
    logic [31:0]       pct_ext;
    logic [1:0]        clase_nx;

    // Male reference table by age; female value is three quarters of it.
    always_comb begin
        tbl = W_PRED'(150);
        unique case (1'b1)
            (age_q == 8'd10): tbl = W_PRED'(155);
            (age_q == 8'd11): tbl = W_PRED'(170);
            (age_q == 8'd12): tbl = W_PRED'(204);
            (age_q == 8'd13): tbl = W_PRED'(250);
            (age_q == 8'd14): tbl = W_PRED'(275);
            (age_q == 8'd15): tbl = W_PRED'(300);
            (age_q == 8'd16): tbl = W_PRED'(320);
            (age_q == 8'd17): tbl = W_PRED'(350);
            (age_q == 8'd18): tbl = W_PRED'(380);
            (age_q >= 8'd19 && age_q <= 8'd24): tbl = W_PRED'(400);
            (age_q == 8'd25): tbl = W_PRED'(402);
            (age_q == 8'd26): tbl = W_PRED'(400);
            (age_q == 8'd27): tbl = W_PRED'(408);
            (age_q == 8'd28): tbl = W_PRED'(405);
            (age_q == 8'd29): tbl = W_PRED'(402);
            (age_q == 8'd30): tbl = W_PRED'(400);
            (age_q >= 8'd31 && age_q <= 8'd35): tbl = W_PRED'(379);
            (age_q >= 8'd36 && age_q <= 8'd45): tbl = W_PRED'(360);
            (age_q >= 8'd46 && age_q <= 8'd53): tbl = W_PRED'(320);
            (age_q >= 8'd54 && age_q <= 8'd60): tbl = W_PRED'(300);
            (age_q >= 8'd61 && age_q <= 8'd65): tbl = W_PRED'(200);
            default: tbl = W_PRED'(150);
        endcase
        pred_tbl = sexo_q ? (tbl - (tbl >> 2)) : tbl;
    end

    // One restoring-divide step plus saturation and classing of the result.
    always_comb begin
        rem_sh = {rem_q, num_q[NW-1]};
        qbit   = 1'b0;
        rem_nx = rem_sh[W_PRED-1:0];
        if (rem_sh >= {1'b0, pred_q}) begin
            qbit   = 1'b1;
            rem_nx = W_PRED'(rem_sh - {1'b0, pred_q});
        end
        quo_nx  = (quo_q << 1) | NW'(qbit);
        pct_nx  = (quo_nx > PCT_MAX) ? '1 : quo_nx[W_PCT-1:0];
        pct_ext = 32'(pct_nx);
        if (pct_ext >= 32'd80) begin
            clase_nx = 2'd0;
        end else if (pct_ext >= 32'd60) begin
            clase_nx = 2'd1;
        end else if (pct_ext >= 32'd40) begin
            clase_nx = 2'd2;
        end else begin
            clase_nx = 2'd3;
        end
    end

    // Next-state logic; nothing moves while the clock enable is low.
    always_comb begin
        state_d     = state_q;
        age_d       = age_q;
        sexo_d      = sexo_q;
        num_d       = num_q;
        pred_d      = pred_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        out_pred_d  = out_pred_q;
        out_pct_d   = out_pct_q;
        out_clase_d = out_clase_q;
        done_d      = done_q;
        if (iCE) begin
            unique case (state_q)
                S_IDLE: begin
                    if (iStart) begin
                        state_d = S_LOOKUP;
                        age_d   = ivEdad;
                        sexo_d  = iSexo;
                        num_d   = NW'(ivMedida) * NW'(100);
                    end
                end
                S_LOOKUP: begin
                    state_d = S_DIVIDE;
                    pred_d  = pred_tbl;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                end
                S_DIVIDE: begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    num_d = num_q << 1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d     = S_DONE;
                        cnt_d       = '0;
                        out_pred_d  = pred_q;
                        out_pct_d   = pct_nx;
                        out_clase_d = clase_nx;
                        done_d      = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q     <= S_IDLE;
            age_q       <= '0;
            sexo_q      <= 1'b0;
            num_q       <= '0;
            pred_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            out_pred_q  <= '0;
            out_pct_q   <= '0;
            out_clase_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            age_q       <= age_d;
            sexo_q      <= sexo_d;
            num_q       <= num_d;
            pred_q      <= pred_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            out_pred_q  <= out_pred_d;
            out_pct_q   <= out_pct_d;
            out_clase_q <= out_clase_d;
            done_q      <= done_d;
        end
    end

    assign ovPred  = out_pred_q;
    assign ovPct   = out_pct_q;
    assign ovClase = out_clase_q;
    assign oBusy   = (state_q != S_IDLE);
    assign oDone   = done_q;

endmodule

// File: doc/spiro_predict.md
SPIRO_PREDICT -- requirements
Module: spiro_predict

Interface
REQ-001 Parameter W_MEAS, default 10, width of the measured-volume input (units of 10 mL).
REQ-002 Parameter W_PRED, default 10, width of the predicted-volume output, same units.
REQ-003 Parameter W_PCT, default 8, width of percent-of-predicted output; saturation ceiling 2^W_PCT-1.
REQ-004 iClk  in  1  single clock; all state changes on its rising edge.
REQ-005 iReset  in  1  synchronous active-high reset.
REQ-006 iCE  in  1  clock enable; no state, counter or output register advances when 0.
REQ-007 iStart  in  1  request to evaluate one measurement; sampled only in IDLE with iCE=1.
REQ-008 ivEdad  in  8  patient age in years, captured with iStart.
REQ-009 iSexo  in  1  0 = male, 1 = female, captured with iStart.
REQ-010 ivMedida  in  W_MEAS  measured forced vital capacity, captured with iStart.
REQ-011 ovPred  out  W_PRED  registered predicted capacity.
REQ-012 ovPct  out  W_PCT  registered floor(100*measured/predicted), saturated.
REQ-013 ovClase  out  2  severity: 0 normal, 1 mild, 2 moderate, 3 severe.
REQ-014 oBusy  out  1  high in every state except IDLE.
REQ-015 oDone  out  1  one-cycle pulse when new results become valid.

Function
REQ-016 States IDLE, LOOKUP, DIVIDE, DONE; transitions occur only on edges with iCE=1.
REQ-017 IDLE->LOOKUP when iStart=1; age, sex and measured value are latched on that edge; iStart is ignored in all other states.
REQ-018 LOOKUP (1 cycle): male table value by age -- 10:155, 11:170, 12:204, 13:250, 14:275, 15:300, 16:320, 17:350, 18:380, 19-24:400, 25:402, 26:400, 27:408, 28:405, 29:402, 30:400, 31-35:379, 36-45:360, 46-53:320, 54-60:300, 61-65:200, any other age: 150.
REQ-019 Female prediction = T - (T>>2) using integer arithmetic (150 -> 113, 400 -> 300); the result is latched into an internal predicted register on the LOOKUP->DIVIDE edge.
REQ-020 DIVIDE: restoring divider producing one quotient bit per enabled cycle; numerator = measured*100, held at width W_MEAS+7; DIVIDE lasts exactly W_MEAS+7 enabled cycles (17 by default), counted by an internal counter.
REQ-021 The divisor is never zero, because the minimum prediction is 113.
REQ-022 Quotient >= 2^W_PCT -> ovPct = 2^W_PCT-1; otherwise ovPct = quotient.
REQ-023 Class thresholds on the saturated ovPct: >=80 gives 0; 60-79 gives 1; 40-59 gives 2; <40 gives 3.
REQ-024 DIVIDE->DONE edge: ovPred, ovPct and ovClase update together.
REQ-025 DONE lasts 1 enabled cycle with oDone=1, then DONE->IDLE.
REQ-026 Latency: oDone goes high W_MEAS+9 enabled cycles after the iStart-sampling edge (19 by default); outputs hold their values until the next DONE.
REQ-027 iCE=0 during any state freezes the FSM, divider and counter; while frozen, oDone holds its level.
REQ-028 iStart asserted in the DONE cycle is ignored; a new request is accepted only once the FSM is back in IDLE.
REQ-029 Input changes after the capture edge do not affect the result in flight.

Reset
REQ-030 iReset=1 overrides iCE and iStart; on the edge it returns the FSM to IDLE and clears ovPred, ovPct, ovClase, oBusy, oDone, the counter and all divider registers.
REQ-031 Reset mid-DIVIDE discards the computation; no oDone pulse follows, and outputs read 0 until the next completed request.

Verification
REQ-032 Male, age 20, measured 400, iCE=1 -> ovPred=400, ovPct=100, ovClase=0; oDone pulses exactly 19 cycles after start; oBusy high for 19 cycles.
REQ-033 Female, age 70, measured 56 -> ovPred=113, ovPct=49, ovClase=2.
REQ-034 Male, age 5, measured 1023 -> quotient 682 saturates: ovPred=150, ovPct=255, ovClase=0.
REQ-035 Male, age 65, measured 79 -> ovPred=200, ovPct=39, ovClase=3; second iStart pulsed mid-DIVIDE is ignored (exactly one oDone).
REQ-036 iCE toggled 1/0 every cycle during male age 27, measured 204 -> result ovPred=408, ovPct=50, ovClase=2 after 38 clocks; reset asserted at DIVIDE cycle 5 of a separate run -> all outputs 0, no oDone.
